// File: rtl/binary_to_rns_serial.sv
// rtl/binary_to_rns_serial.sv - bit-serial binary to residue number system forward converter
//
// Reduces a BIN_W-bit binary operand modulo three MOD_W-bit moduli at once,
// MSB first, one operand bit per clock (Horner: w = (2*w + b) mod m).
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-high reset
//   start               conversion request, only looked at while idle
//   binary              operand, captured on the accepting edge
//   moduli1..3          moduli, captured on the accepting edge
//   residue1..3         registered residues, held between conversions
//   busy                high while converting and during the done cycle
//   done                one-cycle pulse: residues and err newly valid
//   err                 registered with done: a captured modulus was zero

module binary_to_rns_serial #(
    parameter int BIN_W = 7,
    parameter int MOD_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] binary,
    input  logic [MOD_W-1:0] moduli1,
    input  logic [MOD_W-1:0] moduli2,
    input  logic [MOD_W-1:0] moduli3,
    output logic [MOD_W-1:0] residue1,
    output logic [MOD_W-1:0] residue2,
    output logic [MOD_W-1:0] residue3,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BIN_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MOD_W-1:0] m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
    logic [MOD_W-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
    logic [MOD_W-1:0] r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [MOD_W-1:0] nw1, nw2, nw3;
    logic             any_zero;

    // One Horner step. Since w < m, t = 2w + b <= 2m - 1, so a single
    // conditional subtract keeps the remainder below m. With m == 0 the
    // value is meaningless; that channel is forced to zero at the end.
    function automatic logic [MOD_W-1:0] horner_step(
        input logic [MOD_W-1:0] w,
        input logic             b,
        input logic [MOD_W-1:0] m
    );
        logic [MOD_W:0] t;
        logic [MOD_W:0] diff;
        t    = {w, b};
        diff = t - {1'b0, m};
        if (t >= {1'b0, m}) begin
            horner_step = diff[MOD_W-1:0];
        end else begin
            horner_step = t[MOD_W-1:0];
        end
    endfunction

    assign nw1 = horner_step(w1_q, shift_q[BIN_W-1], m1_q);
    assign nw2 = horner_step(w2_q, shift_q[BIN_W-1], m2_q);
    assign nw3 = horner_step(w3_q, shift_q[BIN_W-1], m3_q);

    assign any_zero = (m1_q == '0) || (m2_q == '0) || (m3_q == '0);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        m1_d    = m1_q;
        m2_d    = m2_q;
        m3_d    = m3_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        w3_d    = w3_q;
        r1_d    = r1_q;
        r2_d    = r2_q;
        r3_d    = r3_q;
        err_d   = err_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = binary;
                    m1_d    = moduli1;
                    m2_d    = moduli2;
                    m3_d    = moduli3;
                    w1_d    = '0;
                    w2_d    = '0;
                    w3_d    = '0;
                    cnt_d   = CNT_W'(BIN_W - 1);
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                w1_d    = nw1;
                w2_d    = nw2;
                w3_d    = nw3;
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    // Last bit: publish the final remainders directly.
                    r1_d    = (m1_q == '0) ? '0 : nw1;
                    r2_d    = (m2_q == '0) ? '0 : nw2;
                    r3_d    = (m3_q == '0) ? '0 : nw3;
                    err_d   = any_zero;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            m1_q    <= '0;
            m2_q    <= '0;
            m3_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            r1_q    <= '0;
            r2_q    <= '0;
            r3_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            m1_q    <= m1_d;
            m2_q    <= m2_d;
            m3_q    <= m3_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            r1_q    <= r1_d;
            r2_q    <= r2_d;
            r3_q    <= r3_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign residue1 = r1_q;
    assign residue2 = r2_q;
    assign residue3 = r3_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_binary_to_rns_serial.sv
// tb/tb_binary_to_rns_serial.sv - self-checking bench for binary_to_rns_serial

module tb_binary_to_rns_serial;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] binary;
    logic [2:0] moduli1, moduli2, moduli3;
    logic [2:0] residue1, residue2, residue3;
    logic       busy, done, err;

    int checks = 0;
    int passes = 0;

    binary_to_rns_serial #(.BIN_W(7), .MOD_W(3)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .binary   (binary),
        .moduli1  (moduli1),
        .moduli2  (moduli2),
        .moduli3  (moduli3),
        .residue1 (residue1),
        .residue2 (residue2),
        .residue3 (residue3),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] b;
        logic [2:0] m1, m2, m3;
        logic [2:0] e1, e2, e3;
        logic       e_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Starts one conversion with a single-cycle start pulse and waits for done.
    // lat counts falling edges after the accepting edge (8 = done after 7th edge).
    task automatic run_conv(input logic [6:0] b, input logic [2:0] a1, input logic [2:0] a2,
                            input logic [2:0] a3, output int lat, output int busy_cnt);
        @(negedge clk);
        binary  = b;
        moduli1 = a1;
        moduli2 = a2;
        moduli3 = a3;
        start   = 1'b1;
        lat      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, bcnt, done_cnt;
        int done_at[$];
        logic [2:0] sw_m[3][3];

        vecs[0] = '{b: 7'd100, m1: 3'd3, m2: 3'd5, m3: 3'd7, e1: 3'd1, e2: 3'd0, e3: 3'd2, e_err: 1'b0};
        vecs[1] = '{b: 7'd127, m1: 3'd7, m2: 3'd6, m3: 3'd5, e1: 3'd1, e2: 3'd1, e3: 3'd2, e_err: 1'b0};
        vecs[2] = '{b: 7'd0,   m1: 3'd7, m2: 3'd6, m3: 3'd5, e1: 3'd0, e2: 3'd0, e3: 3'd0, e_err: 1'b0};
        vecs[3] = '{b: 7'd64,  m1: 3'd3, m2: 3'd7, m3: 3'd1, e1: 3'd1, e2: 3'd1, e3: 3'd0, e_err: 1'b0};
        vecs[4] = '{b: 7'd45,  m1: 3'd0, m2: 3'd1, m3: 3'd4, e1: 3'd0, e2: 3'd0, e3: 3'd1, e_err: 1'b1};

        reset   = 1'b1;
        start   = 1'b0;
        binary  = '0;
        moduli1 = '0;
        moduli2 = '0;
        moduli3 = '0;
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_res", {residue1, residue2, residue3}, 0);
        reset = 1'b0;

        // Latency, busy length and single done pulse.
        run_conv(7'd100, 3'd3, 3'd5, 3'd7, lat, bcnt);
        chk("first_latency", lat, 8);
        chk("first_busy_cycles", bcnt, 8);
        @(negedge clk);
        chk("first_done_single", done, 0);
        chk("first_busy_after", busy, 0);
        chk("first_hold_r1", residue1, 1);

        foreach (vecs[i]) begin
            run_conv(vecs[i].b, vecs[i].m1, vecs[i].m2, vecs[i].m3, lat, bcnt);
            chk($sformatf("vec%0d_lat", i), lat, 8);
            chk($sformatf("vec%0d_r1", i), residue1, vecs[i].e1);
            chk($sformatf("vec%0d_r2", i), residue2, vecs[i].e2);
            chk($sformatf("vec%0d_r3", i), residue3, vecs[i].e3);
            chk($sformatf("vec%0d_err", i), err, vecs[i].e_err);
        end

        // start held high; inputs changed mid-conversion.
        @(negedge clk);
        binary  = 7'd100;
        moduli1 = 3'd3;
        moduli2 = 3'd5;
        moduli3 = 3'd7;
        start   = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) begin
                binary  = 7'd127;
                moduli1 = 3'd7;
                moduli2 = 3'd6;
                moduli3 = 3'd5;
            end
            if (k == 11) begin
                binary  = 7'd0;
                moduli1 = 3'd2;
                moduli2 = 3'd2;
                moduli3 = 3'd2;
            end
            if (done) begin
                done_cnt++;
                done_at.push_back(k);
                if (done_cnt == 1) begin
                    chk("held1_res", {residue1, residue2, residue3}, {3'd1, 3'd0, 3'd2});
                    chk("held1_err", err, 0);
                end else begin
                    chk("held2_res", {residue1, residue2, residue3}, {3'd1, 3'd1, 3'd2});
                end
            end
            if (k == 17) start = 1'b0;
        end
        chk("held_done_count", done_cnt, 2);
        chk("held_done1_at", (done_at.size() > 0) ? done_at[0] : -1, 8);
        chk("held_done2_at", (done_at.size() > 1) ? done_at[1] : -1, 17);
        chk("held_idle_after", busy, 0);

        // Asynchronous reset in the middle of a conversion.
        @(negedge clk);
        binary  = 7'd45;
        moduli1 = 3'd0;
        moduli2 = 3'd1;
        moduli3 = 3'd4;
        start   = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_res", {residue1, residue2, residue3}, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk("no_done_after_rst", done_cnt, 0);
        run_conv(7'd100, 3'd3, 3'd5, 3'd7, lat, bcnt);
        chk("post_rst_lat", lat, 8);
        chk("post_rst_res", {residue1, residue2, residue3}, {3'd1, 3'd0, 3'd2});

        // Exhaustive operand sweep against binary % m.
        sw_m[0] = '{3'd2, 3'd3, 3'd5};
        sw_m[1] = '{3'd3, 3'd5, 3'd7};
        sw_m[2] = '{3'd4, 3'd6, 3'd7};
        for (int s = 0; s < 3; s++) begin
            for (int v = 0; v < 128; v++) begin
                run_conv(7'(v), sw_m[s][0], sw_m[s][1], sw_m[s][2], lat, bcnt);
                chk($sformatf("sweep%0d_b%0d_lat", s, v), lat, 8);
                chk($sformatf("sweep%0d_b%0d_r1", s, v), residue1, v % int'(sw_m[s][0]));
                chk($sformatf("sweep%0d_b%0d_r2", s, v), residue2, v % int'(sw_m[s][1]));
                chk($sformatf("sweep%0d_b%0d_r3", s, v), residue3, v % int'(sw_m[s][2]));
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
